spi_packet_rx: RTL and testbench
================================

SPI_PACKET_RX -- requirements
Module: spi_packet_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output word FIFO depth as a power of two, minimum 2.
REQ-002 The block SHALL have parameter MAX_WORDS, default 64, giving the largest legal LEN value.
REQ-003 The block SHALL have parameter TIMEOUT, default 50000, giving the maximum number of clk cycles allowed between bytes inside a frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port byte_recv, input, 8 bits: a received SPI byte, qualified by valid.
REQ-007 The block SHALL have port valid, input, 1 bit: a one-clk pulse per received byte.
REQ-008 The block SHALL have port busy, input, 1 bit: the SPI transmit path is occupied.
REQ-009 The block SHALL have port byte_send, output, 8 bits: the response byte.
REQ-010 The block SHALL have port write, output, 1 bit: a one-clk strobe that loads byte_send into the transmit path.
REQ-011 The block SHALL have ports word_data, output, 32 bits, and word_valid, output, 1 bit: the FIFO head word and its valid flag.
REQ-012 The block SHALL have port word_ready, input, 1 bit: the consumer accepts word_data when word_valid and word_ready are both high.
REQ-013 The block SHALL have ports frame_done, output, 1 bit, and frame_err, output, 1 bit: one-clk end-of-frame pulses.
REQ-014 The block SHALL have port err_code, output, 3 bits: the error code of the last frame, held until the next frame ends.

Function
REQ-015 The frame format SHALL be SYNC (0xA5), then LEN, then LEN*4 payload bytes, then CSUM, where CSUM is the XOR of LEN and all payload bytes.
REQ-016 The state machine SHALL have states IDLE, LEN, PAYLOAD, CSUM and RESP; bytes are consumed only on cycles where valid is high.
REQ-017 In IDLE, a byte of 0xA5 SHALL move the FSM to LEN; any other byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-018 In LEN, a LEN of 0 or a LEN greater than MAX_WORDS SHALL record err 1 (bad length) and move the FSM directly to RESP; otherwise the FSM SHALL load the word counter and move to PAYLOAD.
REQ-019 In PAYLOAD, bytes SHALL be assembled little-endian, with the first byte in bits [7:0]; the fourth byte SHALL complete the word and push it into the FIFO on the following cycle.
REQ-020 A completed word arriving when the FIFO is full SHALL be dropped and record err 3 (overflow); reception of the frame SHALL continue.
REQ-021 After the last payload byte the FSM SHALL move to CSUM; a mismatching checksum SHALL record err 2.
REQ-022 Only the first error of a frame SHALL be retained; words already pushed into the FIFO SHALL NOT be retracted.
REQ-023 In LEN, PAYLOAD and CSUM, an idle counter SHALL reset on every valid; reaching TIMEOUT cycles SHALL record err 4 and move the FSM to RESP.
REQ-024 On entering RESP, err_code SHALL update, with 0 meaning no error, and frame_done, or frame_err if err is not 0, SHALL pulse for one cycle.
REQ-025 In RESP, the block SHALL wait for busy==0, then assert write for exactly one cycle with byte_send = 0x06 (ACK) if err is 0, else 0x15 (NAK), and return to IDLE on the next cycle.
REQ-026 Bytes arriving while the FSM is in RESP SHALL be ignored.
REQ-027 The FIFO SHALL support a simultaneous push and pop when full or when empty.
REQ-028 word_valid SHALL be high exactly when the FIFO is non-empty.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, empty the FIFO, and clear all counters and the assembly register.
REQ-030 During reset, write, word_valid, frame_done and frame_err SHALL be 0, and byte_send, word_data and err_code SHALL be 0.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame without sending any response.

Structure
REQ-032 A shared package spi_pkg SHALL hold the state enum, the SYNC, ACK and NAK byte constants, and the err_code enum (NONE=0, BADLEN=1, CSUM=2, OVF=3, TMO=4).
REQ-033 The FIFO SHALL be a separate sub-module, spi_word_fifo, parameterised by depth, with push/pop/full/empty ports.

Verification
REQ-034 Bytes A5 01 11 22 33 44 CSUM=0x01^0x11^0x22^0x33^0x44 SHALL produce word 0x44332211, frame_done, err_code 0 and one write of 0x06.
REQ-035 Bytes A5 02 followed by 8 payload bytes and a wrong CSUM SHALL produce two words, frame_err, err_code 2 and a NAK of 0x15.
REQ-036 Bytes A5 00, and separately A5 41 with MAX_WORDS=64, SHALL each produce an immediate NAK with err_code 1 and no FIFO push.
REQ-037 With word_ready=0 and a 6-word frame, FIFO_DEPTH=4 SHALL hold 4 words and the bench SHALL see err_code 3 and a NAK; after word_ready=1 exactly 4 words SHALL drain.
REQ-038 A5 03 followed by 2 bytes and then silence SHALL time out after TIMEOUT cycles with err_code 4 and a NAK; with busy held high for 10 cycles, write SHALL fire on the first cycle busy is low.
REQ-039 Asserting rst mid-payload SHALL cause no write and leave word_valid at 0, and a following valid frame SHALL be accepted normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI packet receiver: FSM states, framing bytes, error codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_BADLEN = 3'd1,
    ERR_CSUM   = 3'd2,
    ERR_OVF    = 3'd3,
    ERR_TMO    = 3'd4
  } err_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // An error already latched for the frame always wins over a newer one.
  function automatic err_t first_err(input err_t cur, input err_t nw);
    return (cur != ERR_NONE) ? cur : nw;
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Power-of-two word FIFO; a pop frees a slot for a push in the same cycle when full.
module spi_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_packet_rx.sv
// Frame receiver: SYNC, LEN, LEN*4 payload bytes, XOR checksum; emits words to a FIFO and ACK/NAK.
import spi_pkg::*;

module spi_packet_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 64,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_recv,
  input  logic        valid,
  input  logic        busy,
  output logic [7:0]  byte_send,
  output logic        write,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  err_t          err_q;
  err_t          err_base;
  err_t          err_nx;
  logic          go_resp;
  logic [7:0]    csum_q;
  logic [7:0]    words_left;
  logic [1:0]    byte_idx;
  logic [31:0]   asm_q;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;
  logic          bad_len;
  logic          vld_p1;
  logic [31:0]   word_p1;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf_evt;

  assign word_valid  = !fifo_empty;
  assign ovf_evt     = vld_p1 && fifo_full && !word_ready;
  assign err_base    = first_err(err_q, ovf_evt ? ERR_OVF : ERR_NONE);
  assign timeout_hit = (idle_cnt == TW'(TIMEOUT - 1)) && !valid;
  assign bad_len     = (byte_recv == 8'd0) || ({24'd0, byte_recv} > 32'(MAX_WORDS));

  always_comb begin
    err_nx  = err_base;
    go_resp = 1'b0;
    case (state)
      ST_LEN: begin
        if (valid && bad_len) begin
          go_resp = 1'b1;
          err_nx  = first_err(err_base, ERR_BADLEN);
        end else if (timeout_hit) begin
          go_resp = 1'b1;
          err_nx  = first_err(err_base, ERR_TMO);
        end
      end
      ST_PAYLOAD: begin
        if (timeout_hit) begin
          go_resp = 1'b1;
          err_nx  = first_err(err_base, ERR_TMO);
        end
      end
      ST_CSUM: begin
        if (valid) begin
          go_resp = 1'b1;
          if (byte_recv != csum_q) err_nx = first_err(err_base, ERR_CSUM);
        end else if (timeout_hit) begin
          go_resp = 1'b1;
          err_nx  = first_err(err_base, ERR_TMO);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      err_q      <= ERR_NONE;
      err_code   <= 3'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      write      <= 1'b0;
      byte_send  <= 8'd0;
      csum_q     <= 8'd0;
      words_left <= 8'd0;
      byte_idx   <= 2'd0;
      asm_q      <= 32'd0;
      idle_cnt   <= '0;
      vld_p1     <= 1'b0;
      word_p1    <= 32'd0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      write      <= 1'b0;
      vld_p1     <= 1'b0;
      err_q      <= err_nx;

      if (state == ST_LEN || state == ST_PAYLOAD || state == ST_CSUM)
        idle_cnt <= valid ? '0 : idle_cnt + 1'b1;
      else
        idle_cnt <= '0;

      case (state)
        ST_IDLE: begin
          err_q <= ERR_NONE;
          if (valid && byte_recv == SYNC_BYTE) state <= ST_LEN;
        end
        ST_LEN: begin
          if (valid && !bad_len) begin
            words_left <= byte_recv;
            csum_q     <= byte_recv;
            byte_idx   <= 2'd0;
            asm_q      <= 32'd0;
            state      <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (valid) begin
            csum_q                 <= csum_q ^ byte_recv;
            asm_q[8*byte_idx +: 8] <= byte_recv;
            byte_idx               <= byte_idx + 1'b1;
            // Fourth byte closes the word; the FIFO sees it one cycle later.
            if (byte_idx == 2'd3) begin
              vld_p1     <= 1'b1;
              word_p1    <= {byte_recv, asm_q[23:0]};
              words_left <= words_left - 1'b1;
              if (words_left == 8'd1) state <= ST_CSUM;
            end
          end
        end
        ST_RESP: begin
          if (write) begin
            state <= ST_IDLE;
          end else if (!busy) begin
            write     <= 1'b1;
            byte_send <= (err_q == ERR_NONE) ? ACK_BYTE : NAK_BYTE;
          end
        end
        default: ;
      endcase

      if (go_resp) begin
        state      <= ST_RESP;
        err_code   <= err_nx;
        frame_done <= (err_nx == ERR_NONE);
        frame_err  <= (err_nx != ERR_NONE);
      end
    end
  end

  spi_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (word_p1),
    .pop       (word_ready),
    .pop_data  (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_packet_rx.sv
// Directed bench for spi_packet_rx with hand-computed frames, checksums and response codes.
module tb_spi_packet_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_recv;
  logic        valid;
  logic        busy;
  logic [7:0]  byte_send;
  logic        write;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;

  int n_vec;
  int n_miss;

  int          n_write;
  int          n_done;
  int          n_ferr;
  logic [7:0]  last_send;
  logic [31:0] words[$];
  logic [7:0]  tx_q[$];

  spi_packet_rx #(
    .FIFO_DEPTH (4),
    .MAX_WORDS  (64),
    .TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_recv  (byte_recv),
    .valid      (valid),
    .busy       (busy),
    .byte_send  (byte_send),
    .write      (write),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_write   = 0;
    n_done    = 0;
    n_ferr    = 0;
    last_send = 8'h00;
  end

  always @(negedge clk) begin
    if (write) begin
      n_write   <= n_write + 1;
      last_send <= byte_send;
    end
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (word_valid && word_ready) words.push_back(word_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_all();
    while (tx_q.size() != 0) begin
      @(posedge clk); #1;
      valid     = 1'b1;
      byte_recv = tx_q.pop_front();
      @(posedge clk); #1;
      valid     = 1'b0;
    end
  endtask

  task automatic wait_write(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (write) break;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  int b_write, b_done, b_ferr, b_words, tcnt;

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    valid      = 1'b0;
    byte_recv  = 8'h00;
    busy       = 1'b0;
    word_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_byte_send", {24'd0, byte_send}, 32'd0);
    chk("rst_word_data", word_data, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);

    // Good single-word frame, checksum 0x45
    b_write = n_write; b_done = n_done; b_ferr = n_ferr; b_words = words.size();
    tx_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_all();
    wait_write(20);
    chk("f1_nwords", words.size() - b_words, 1);
    if (words.size() > b_words) chk("f1_word", words[b_words], 32'h44332211);
    chk("f1_done", n_done - b_done, 1);
    chk("f1_ferr", n_ferr - b_ferr, 0);
    chk("f1_err_code", {29'd0, err_code}, 32'd0);
    chk("f1_nwrite", n_write - b_write, 1);
    chk("f1_send", {24'd0, last_send}, 32'h06);

    // Two words with bad checksum (correct would be 0x0A)
    b_write = n_write; b_done = n_done; b_ferr = n_ferr; b_words = words.size();
    tx_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    send_all();
    wait_write(20);
    chk("f2_nwords", words.size() - b_words, 2);
    if (words.size() >= b_words + 2) begin
      chk("f2_word0", words[b_words], 32'h04030201);
      chk("f2_word1", words[b_words+1], 32'h08070605);
    end
    chk("f2_ferr", n_ferr - b_ferr, 1);
    chk("f2_done", n_done - b_done, 0);
    chk("f2_err_code", {29'd0, err_code}, 32'd2);
    chk("f2_send", {24'd0, last_send}, 32'h15);

    // Zero length
    b_write = n_write; b_words = words.size();
    tx_q = '{8'hA5, 8'h00};
    send_all();
    wait_write(10);
    chk("len0_err_code", {29'd0, err_code}, 32'd1);
    chk("len0_send", {24'd0, last_send}, 32'h15);
    chk("len0_nwrite", n_write - b_write, 1);
    chk("len0_nwords", words.size() - b_words, 0);

    // Length 65 exceeds MAX_WORDS
    b_write = n_write; b_words = words.size();
    tx_q = '{8'hA5, 8'h41};
    send_all();
    wait_write(10);
    chk("len65_err_code", {29'd0, err_code}, 32'd1);
    chk("len65_send", {24'd0, last_send}, 32'h15);
    chk("len65_nwrite", n_write - b_write, 1);
    chk("len65_nwords", words.size() - b_words, 0);

    // Six words into a four-deep FIFO, consumer stalled; checksum 0x06^0x18 = 0x1E
    word_ready = 1'b0;
    b_write = n_write; b_words = words.size();
    tx_q = '{8'hA5, 8'h06};
    for (int i = 1; i <= 24; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h1E);
    send_all();
    wait_write(20);
    chk("ovf_err_code", {29'd0, err_code}, 32'd3);
    chk("ovf_send", {24'd0, last_send}, 32'h15);
    chk("ovf_word_valid", {31'd0, word_valid}, 32'd1);
    chk("ovf_held", words.size() - b_words, 0);
    @(posedge clk); #1;
    word_ready = 1'b1;
    cycles(10);
    chk("ovf_drained", words.size() - b_words, 4);
    if (words.size() >= b_words + 4) begin
      chk("ovf_word0", words[b_words], 32'h04030201);
      chk("ovf_word3", words[b_words+3], 32'h100F0E0D);
    end
    chk("ovf_empty", {31'd0, word_valid}, 32'd0);

    // Timeout mid-payload with transmit path busy
    busy = 1'b1;
    b_write = n_write; b_ferr = n_ferr;
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22};
    send_all();
    tcnt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_err) begin
        tcnt = i;
        break;
      end
    end
    chk("tmo_latency", tcnt, 101);
    chk("tmo_err_code", {29'd0, err_code}, 32'd4);
    repeat (10) @(negedge clk);
    chk("tmo_busy_hold", n_write - b_write, 0);
    @(posedge clk); #1;
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_write", {31'd0, write}, 32'd1);
    chk("tmo_nak", {24'd0, byte_send}, 32'h15);
    @(negedge clk);
    chk("tmo_write_pulse", {31'd0, write}, 32'd0);
    chk("tmo_no_words", {31'd0, word_valid}, 32'd0);

    // Reset mid-payload, then a clean frame
    word_ready = 1'b0;
    b_write = n_write;
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_all();
    cycles(2);
    chk("mid_word_valid", {31'd0, word_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_word_valid", {31'd0, word_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    word_ready = 1'b1;
    cycles(20);
    chk("mid_no_write", n_write - b_write, 0);
    b_write = n_write; b_done = n_done; b_words = words.size();
    tx_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_all();
    wait_write(20);
    chk("post_nwords", words.size() - b_words, 1);
    if (words.size() > b_words) chk("post_word", words[b_words], 32'h44332211);
    chk("post_done", n_done - b_done, 1);
    chk("post_send", {24'd0, last_send}, 32'h06);
    chk("post_err_code", {29'd0, err_code}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
